// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - rising-edge detector bank with round-robin event serialiser
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   reset    - asynchronous active-high reset
//   level    - N per-channel level inputs, synchronous to clk
//   ready    - consumer accepts the presented event when high with valid
//   clr_ovf  - single-cycle pulse clearing every overflow flag
//   valid    - an event is presented on chan_id
//   chan_id  - channel index of the presented event
//   ovf      - sticky per-channel overflow flags

module edge_event_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    level,
  input  logic            ready,
  input  logic            clr_ovf,
  output logic            valid,
  output logic [ID_W-1:0] chan_id,
  output logic [N-1:0]    ovf
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HOLD = 2'b01;

  logic [N-1:0]    level_q, level_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    ovf_q, ovf_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] chan_id_q, chan_id_d;
  logic [1:0]      state_q, state_d;
  logic            valid_q, valid_d;

  logic [N-1:0]    rise;
  logic [N-1:0]    load_mask;
  logic [N-1:0]    ovf_set;
  logic            any_pend;
  logic            load_en;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] winner_next;
  int              scan_idx;

  assign rise     = level & ~level_q;
  assign any_pend = |pend_q;

  // Round-robin pick over registered pend only. Scanning from the far end
  // back towards ptr lets the last hit be the closest one after ptr.
  always_comb begin
    winner   = '0;
    scan_idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= N) begin
        scan_idx = scan_idx - N;
      end
      if (pend_q[scan_idx[ID_W-1:0]]) begin
        winner = scan_idx[ID_W-1:0];
      end
    end
  end

  assign winner_next = (winner == ID_W'(N - 1)) ? '0 : winner + ID_W'(1);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    chan_id_d = chan_id_q;
    load_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (any_pend) begin
          load_en = 1'b1;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        valid_d = 1'b1;
        if (ready) begin
          // Back-to-back: the accepted event is replaced on the same edge.
          if (any_pend) begin
            load_en = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    if (load_en) begin
      chan_id_d = winner;
    end
  end

  always_comb begin
    load_mask = '0;
    if (load_en) begin
      load_mask = N'(1) << winner;
    end
  end

  // A rise on the channel being loaded re-arms pend rather than overflowing.
  assign ovf_set = rise & pend_q & ~load_mask;
  assign pend_d  = (pend_q & ~load_mask) | rise;
  // Set dominates a coincident clear.
  assign ovf_d   = (clr_ovf ? '0 : ovf_q) | ovf_set;
  assign ptr_d   = load_en ? winner_next : ptr_q;
  assign level_d = level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q   <= '0;
      pend_q    <= '0;
      ovf_q     <= '0;
      ptr_q     <= '0;
      chan_id_q <= '0;
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      ptr_q     <= ptr_d;
      chan_id_q <= chan_id_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
    end
  end

  assign valid   = valid_q;
  assign chan_id = chan_id_q;
  assign ovf     = ovf_q;

endmodule
